arbiter_rr_reg: RTL and testbench

//  N-way round-robin arbiter with a registered valid/ready output stage.
//  It shares one downstream consumer (e.g. the instruction or memory port

---
 rtl/cicero_arb_pkg.sv | 12 +
 rtl/rr_select.sv | 54 +++++
 rtl/arbiter_rr_reg.sv | 92 +++++++++
 tb/tb_arbiter_rr_reg.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cicero_arb_pkg.sv
// Shared arbiter helpers: index-width rule used by every arbiter in the design.
package cicero_arb_pkg;

  // Width of a requester index; a single requester still gets one bit.
  function automatic int idx_width(input int n);
    if (n <= 1) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin selector: first set request at or after ptr,
// found by scanning a doubled request vector starting at offset ptr.
module rr_select
  import cicero_arb_pkg::*;
#(
  parameter int N_INPUTS = 4,
  parameter int IDX_W    = idx_width(N_INPUTS)
) (
  input  logic [N_INPUTS-1:0] req,
  input  logic [IDX_W-1:0]    ptr,
  output logic [N_INPUTS-1:0] grant_onehot,
  output logic [IDX_W-1:0]    grant_idx,
  output logic                any
);

  localparam int SW = $clog2(2 * N_INPUTS);

  logic [2*N_INPUTS-1:0] req2;
  logic [N_INPUTS-1:0]   rot;
  logic [IDX_W-1:0]      off;
  logic [SW-1:0]         sum;

  assign req2 = {req, req};

  // rot[k] is the request that sits k places after ptr
  generate
    for (genvar gi = 0; gi < N_INPUTS; gi++) begin : g_rot
      assign rot[gi] = req2[SW'(ptr) + SW'(gi)];
    end
  endgenerate

  always_comb begin
    off = '0;
    sum = '0;
    any = |rot;
    for (int k = N_INPUTS - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off = IDX_W'(k);
      end
    end
    sum = SW'(ptr) + SW'(off);
    if (sum >= SW'(N_INPUTS)) begin
      sum = sum - SW'(N_INPUTS);
    end
    grant_idx = IDX_W'(sum);
  end

  generate
    for (genvar gi = 0; gi < N_INPUTS; gi++) begin : g_onehot
      assign grant_onehot[gi] = any && (grant_idx == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/arbiter_rr_reg.sv
// N-way round-robin arbiter feeding one registered valid/ready output stage.
// The output register decouples requester timing from the consumer.
module arbiter_rr_reg
  import cicero_arb_pkg::*;
#(
  parameter  int N_INPUTS = 4,
  parameter  int DWIDTH   = 8,
  localparam int IDX_W    = idx_width(N_INPUTS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_INPUTS-1:0]          in_valid,
  input  logic [N_INPUTS*DWIDTH-1:0]   in_data,
  output logic [N_INPUTS-1:0]          in_ready,
  output logic                         out_valid,
  output logic [DWIDTH-1:0]            out_data,
  output logic [IDX_W-1:0]             out_src,
  input  logic                         out_ready
);

  logic [IDX_W-1:0]    ptr_reg;
  logic [IDX_W-1:0]    ptr_next;
  logic [IDX_W-1:0]    grant_idx;
  logic [N_INPUTS-1:0] grant_onehot;
  logic                any_req;
  logic                can_load;
  logic                accept;
  logic                out_valid_reg;
  logic [DWIDTH-1:0]   out_data_reg;
  logic [IDX_W-1:0]    out_src_reg;
  logic [DWIDTH-1:0]   sel_data;
  logic [DWIDTH-1:0]   data_arr [N_INPUTS];

  rr_select #(
    .N_INPUTS (N_INPUTS),
    .IDX_W    (IDX_W)
  ) u_sel (
    .req          (in_valid),
    .ptr          (ptr_reg),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .any          (any_req)
  );

  assign can_load = ~out_valid_reg | out_ready;
  assign accept   = any_req & can_load;
  // Reset gates the grant so no requester is told it was taken while held in reset.
  assign in_ready = (accept & ~rst) ? grant_onehot : '0;

  generate
    for (genvar gi = 0; gi < N_INPUTS; gi++) begin : g_data
      assign data_arr[gi] = in_data[gi*DWIDTH +: DWIDTH];
    end
  endgenerate

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (grant_onehot[i]) begin
        sel_data = data_arr[i];
      end
    end
  end

  always_comb begin
    ptr_next = '0;
    if (N_INPUTS > 1 && grant_idx != IDX_W'(N_INPUTS - 1)) begin
      ptr_next = grant_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_src_reg   <= '0;
      ptr_reg       <= '0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= sel_data;
      out_src_reg   <= grant_idx;
      ptr_reg       <= ptr_next;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_src   = out_src_reg;

endmodule

// File: tb/tb_arbiter_rr_reg.sv
// Directed bench for arbiter_rr_reg: a 4-input and a 3-input instance.
module tb_arbiter_rr_reg;

  logic        clk;
  logic        rst;

  logic [3:0]  in_valid4;
  logic [31:0] in_data4;
  logic [3:0]  in_ready4;
  logic        out_valid4;
  logic [7:0]  out_data4;
  logic [1:0]  out_src4;
  logic        out_ready4;

  logic [2:0]  in_valid3;
  logic [23:0] in_data3;
  logic [2:0]  in_ready3;
  logic        out_valid3;
  logic [7:0]  out_data3;
  logic [1:0]  out_src3;
  logic        out_ready3;

  int errors = 0;
  int checks = 0;

  arbiter_rr_reg #(.N_INPUTS(4), .DWIDTH(8)) u4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid4),
    .in_data   (in_data4),
    .in_ready  (in_ready4),
    .out_valid (out_valid4),
    .out_data  (out_data4),
    .out_src   (out_src4),
    .out_ready (out_ready4)
  );

  arbiter_rr_reg #(.N_INPUTS(3), .DWIDTH(8)) u3 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid3),
    .in_data   (in_data3),
    .in_ready  (in_ready3),
    .out_valid (out_valid3),
    .out_data  (out_data3),
    .out_src   (out_src3),
    .out_ready (out_ready3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (!rst && out_valid4 && out_ready4)
      $display("xfer4 src=%0d data=%h", out_src4, out_data4);
    if (!rst && out_valid3 && out_ready3)
      $display("xfer3 src=%0d data=%h", out_src3, out_data3);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out4(input string tag, input logic v, input logic [7:0] d, input logic [1:0] s);
    chk({tag, "_valid"}, 32'(out_valid4), 32'(v));
    chk({tag, "_data"},  32'(out_data4),  32'(d));
    chk({tag, "_src"},   32'(out_src4),   32'(s));
  endtask

  initial begin
    logic [7:0] exp_d;
    logic [1:0] exp_s;

    rst        = 1'b1;
    in_valid4  = 4'b1111;
    in_data4   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    out_ready4 = 1'b1;
    in_valid3  = 3'b000;
    in_data3   = {8'hB2, 8'hB1, 8'hB0};
    out_ready3 = 1'b1;

    // 1: reset and idle
    #2;
    chk("rst_in_ready", 32'(in_ready4), 32'h0);
    chk_out4("rst", 1'b0, 8'h00, 2'd0);
    tick();
    in_valid4 = 4'b0000;
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("idle_valid", 32'(out_valid4), 32'h0);
      chk("idle_in_ready", 32'(in_ready4), 32'h0);
    end

    // 2: all requesting, full throughput, rotating grant
    in_valid4 = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_in_ready", 32'(in_ready4), 32'(4'b0001 << (k % 4)));
      tick();
      exp_d = 8'hA0 + 8'(k % 4);
      exp_s = 2'(k % 4);
      chk_out4("rr", 1'b1, exp_d, exp_s);
    end
    in_valid4 = 4'b0000;
    tick();
    chk_out4("drain", 1'b0, 8'hA0, 2'd0);

    // 3: ptr=1, lone request from 1, then ptr=2 with lone request from 1, then 0110
    in_valid4 = 4'b0010;
    #1;
    chk("lone1_in_ready", 32'(in_ready4), 32'h2);
    tick();
    chk_out4("lone1", 1'b1, 8'hA1, 2'd1);
    #1;
    chk("wrap1_in_ready", 32'(in_ready4), 32'h2);
    tick();
    chk_out4("wrap1", 1'b1, 8'hA1, 2'd1);
    in_valid4 = 4'b0110;
    #1;
    chk("p2_in_ready", 32'(in_ready4), 32'h4);
    tick();
    chk_out4("p2", 1'b1, 8'hA2, 2'd2);
    in_valid4 = 4'b0000;
    tick();
    chk("p2_drain", 32'(out_valid4), 32'h0);

    // 4: stall with full output, then release without a bubble (ptr=3)
    in_valid4 = 4'b1111;
    tick();
    chk_out4("fill", 1'b1, 8'hA3, 2'd3);
    out_ready4 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall_in_ready", 32'(in_ready4), 32'h0);
      tick();
      chk_out4("stall", 1'b1, 8'hA3, 2'd3);
    end
    out_ready4 = 1'b1;
    #1;
    chk("unstall_in_ready", 32'(in_ready4), 32'h1);
    tick();
    chk_out4("unstall", 1'b1, 8'hA0, 2'd0);
    in_valid4 = 4'b0000;
    tick();
    chk("unstall_drain", 32'(out_valid4), 32'h0);

    // 5: three inputs, pointer wraps 2 -> 0
    in_valid3 = 3'b111;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("n3_in_ready", 32'(in_ready3), 32'(3'b001 << (k % 3)));
      tick();
      chk("n3_valid", 32'(out_valid3), 32'h1);
      chk("n3_src", 32'(out_src3), 32'(k % 3));
      chk("n3_data", 32'(out_data3), 32'(8'hB0 + 8'(k % 3)));
    end
    in_valid3 = 3'b000;
    tick();
    chk("n3_drain", 32'(out_valid3), 32'h0);

    // 6: async reset while holding a stalled item (ptr=1)
    in_valid4 = 4'b1111;
    tick();
    chk_out4("pre_rst", 1'b1, 8'hA1, 2'd1);
    out_ready4 = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_out4("async_rst", 1'b0, 8'h00, 2'd0);
    chk("async_rst_in_ready", 32'(in_ready4), 32'h0);
    #2;
    rst = 1'b0;
    out_ready4 = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready4), 32'h1);
    tick();
    chk_out4("post_rst", 1'b1, 8'hA0, 2'd0);
    in_valid4 = 4'b0000;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
